// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage controller.
// Drives the data-memory request from the EX/MEM register and holds it until mem_rdy.
// Stalls upstream while busy and registers load data or the ALU result toward MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (bounded ACCESS wait with a sticky mem_err).
module mem_stage_ctrl #(
  parameter int unsigned DW             = 16,
  parameter int unsigned RW             = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWrite_in,
  input  logic          MemWrite_in,
  input  logic          MemRead_in,
  input  logic          mem_to_reg_in,
  input  logic          call_in,
  input  logic          ret_future_in,
  input  logic          HALT_in,
  input  logic [RW-1:0] reg_rd_in,
  input  logic [DW-1:0] alu_result_in,
  input  logic [DW-1:0] save_word_data_in,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic          stall,
  output logic          wb_regwrite,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_call,
  output logic          wb_ret,
  output logic          wb_halt,
  output logic          mem_err
);

  localparam int unsigned CW = 8;

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mem_re, w_mem_re_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [DW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0] r_rdata_q, w_rdata_nxt;
  logic          r_wb_regwrite, w_wb_regwrite_nxt;
  logic [RW-1:0] r_wb_rd, w_wb_rd_nxt;
  logic [DW-1:0] r_wb_data, w_wb_data_nxt;
  logic          r_wb_call, w_wb_call_nxt;
  logic          r_wb_ret, w_wb_ret_nxt;
  logic          r_wb_halt, w_wb_halt_nxt;
  logic          w_memop;
  logic          w_stall;
`ifdef MEM_TIMEOUT_EN
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_err, w_err_nxt;
`endif

  assign w_memop = MemRead_in | MemWrite_in;
  // Stall is gated by rst so a reset mid-access releases upstream immediately.
  assign w_stall = ~rst & (((r_state == S_IDLE) & w_memop) | (r_state == S_ACCESS));

  // Next-state, memory request and writeback payload.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_re_nxt      = r_mem_re;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_rdata_nxt       = r_rdata_q;
    w_wb_regwrite_nxt = 1'b0;
    w_wb_rd_nxt       = r_wb_rd;
    w_wb_data_nxt     = r_wb_data;
    w_wb_call_nxt     = 1'b0;
    w_wb_ret_nxt      = 1'b0;
    w_wb_halt_nxt     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
    w_err_nxt         = r_err;
    w_cnt_inc         = r_cnt + CW'(1);
`endif

    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_state_nxt     = S_ACCESS;
          w_mem_addr_nxt  = alu_result_in;
          w_mem_wdata_nxt = save_word_data_in;
          w_mem_we_nxt    = MemWrite_in;
          w_mem_re_nxt    = MemRead_in & ~MemWrite_in;
`ifdef MEM_TIMEOUT_EN
          w_cnt_nxt       = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (mem_rdy) begin
          if (r_mem_re) w_rdata_nxt = mem_rdata;
          w_mem_re_nxt = 1'b0;
          w_mem_we_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(TIMEOUT_CYCLES)) begin
            w_err_nxt    = 1'b1;
            w_mem_re_nxt = 1'b0;
            w_mem_we_nxt = 1'b0;
            w_rdata_nxt  = '0;
            w_state_nxt  = S_DONE;
          end
        end
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A stall inserts a bubble; rd and data simply hold.
    if (!w_stall) begin
      w_wb_regwrite_nxt = RegWrite_in;
      w_wb_rd_nxt       = reg_rd_in;
      w_wb_call_nxt     = call_in;
      w_wb_ret_nxt      = ret_future_in;
      w_wb_halt_nxt     = HALT_in;
      w_wb_data_nxt     = (mem_to_reg_in && (r_state == S_DONE)) ? r_rdata_q : alu_result_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_rdata_q     <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_wb_call     <= 1'b0;
      r_wb_ret      <= 1'b0;
      r_wb_halt     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt         <= '0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_mem_re      <= w_mem_re_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_rdata_q     <= w_rdata_nxt;
      r_wb_regwrite <= w_wb_regwrite_nxt;
      r_wb_rd       <= w_wb_rd_nxt;
      r_wb_data     <= w_wb_data_nxt;
      r_wb_call     <= w_wb_call_nxt;
      r_wb_ret      <= w_wb_ret_nxt;
      r_wb_halt     <= w_wb_halt_nxt;
`ifdef MEM_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
      r_err         <= w_err_nxt;
`endif
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign stall       = w_stall;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign wb_call     = r_wb_call;
  assign wb_ret      = r_wb_ret;
  assign wb_halt     = r_wb_halt;
`ifdef MEM_TIMEOUT_EN
  assign mem_err     = r_err;
`else
  assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: latency-schedule model checked every cycle plus literal pins.
module tb_mem_stage_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic          clk, rst;
  logic          RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in;
  logic          call_in, ret_future_in, HALT_in;
  logic [RW-1:0] reg_rd_in;
  logic [DW-1:0] alu_result_in, save_word_data_in;
  logic          mem_rdy;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_re, mem_we, stall;
  logic          wb_regwrite, wb_call, wb_ret, wb_halt, mem_err;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  mem_stage_ctrl #(.DW(DW), .RW(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .mem_to_reg_in(mem_to_reg_in), .call_in(call_in), .ret_future_in(ret_future_in),
    .HALT_in(HALT_in), .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in),
    .save_word_data_in(save_word_data_in), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .stall(stall), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_call(wb_call), .wb_ret(wb_ret), .wb_halt(wb_halt), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the current cycle, derived from the latency rules.
  logic          e_stall, e_re, e_we, e_err;
  logic [DW-1:0] e_addr, e_wdata, e_wb_data, m_rdata_q;
  logic          e_wb_regwrite, e_wb_call, e_wb_ret, e_wb_halt;
  logic [RW-1:0] e_wb_rd;
  logic          chk_en;
  int            checks, failures;
  int            n_re, n_we, n_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_re", 32'(mem_re), 32'(e_re));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      if (e_re || e_we) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      chk("wb_regwrite", 32'(wb_regwrite), 32'(e_wb_regwrite));
      chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
      chk("wb_data", 32'(wb_data), 32'(e_wb_data));
      chk("wb_call", 32'(wb_call), 32'(e_wb_call));
      chk("wb_ret", 32'(wb_ret), 32'(e_wb_ret));
      chk("wb_halt", 32'(wb_halt), 32'(e_wb_halt));
      chk("mem_err", 32'(mem_err), 32'(e_err));
      n_re    += int'(mem_re);
      n_we    += int'(mem_we);
      n_stall += int'(stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    e_wb_regwrite = 1'b0;
    e_wb_call     = 1'b0;
    e_wb_ret      = 1'b0;
    e_wb_halt     = 1'b0;
  endtask

  task automatic model_reset();
    e_stall = 0; e_re = 0; e_we = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_wb_data = '0; m_rdata_q = '0;
    e_wb_regwrite = 0; e_wb_rd = '0; e_wb_call = 0; e_wb_ret = 0; e_wb_halt = 0;
  endtask

  task automatic zero_counts();
    n_re = 0; n_we = 0; n_stall = 0;
  endtask

  // Non-memory instruction: one cycle to writeback; mem_rdy=1 must be ignored.
  task automatic alu_op(input logic rw, input logic [RW-1:0] rd, input logic [DW-1:0] alu,
                        input logic [2:0] flags);
    RegWrite_in = rw; MemRead_in = 0; MemWrite_in = 0; mem_to_reg_in = 0;
    {call_in, ret_future_in, HALT_in} = flags;
    reg_rd_in = rd; alu_result_in = alu; save_word_data_in = 16'h5A5A;
    mem_rdy = 1; mem_rdata = 16'($urandom);
    e_stall = 0; e_re = 0; e_we = 0;
    tick();
    e_wb_regwrite = rw; e_wb_rd = rd; e_wb_data = alu;
    {e_wb_call, e_wb_ret, e_wb_halt} = flags;
  endtask

  // Memory instruction with 'waits' cycles before mem_rdy; inputs held while stalled.
  task automatic mem_op(input logic rd_en, input logic wr_en, input logic m2r, input logic rw,
                        input logic [RW-1:0] rd, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int waits, input logic [2:0] flags);
    logic is_rd;
    logic tout;
    int   n_acc;
    is_rd = rd_en & ~wr_en;
`ifdef MEM_TIMEOUT_EN
    tout = (waits >= int'(TO));
`else
    tout = 1'b0;
`endif
    n_acc = tout ? int'(TO) : waits + 1;
    RegWrite_in = rw; MemRead_in = rd_en; MemWrite_in = wr_en; mem_to_reg_in = m2r;
    {call_in, ret_future_in, HALT_in} = flags;
    reg_rd_in = rd; alu_result_in = addr; save_word_data_in = wdata;
    mem_rdy = 1; mem_rdata = 16'($urandom);
    e_stall = 1; e_re = 0; e_we = 0;
    tick();
    bubble();
    for (int k = 0; k < n_acc; k++) begin
      mem_rdy   = (!tout && k == waits);
      mem_rdata = (k == waits) ? rdata : 16'($urandom);
      e_stall = 1; e_re = is_rd; e_we = wr_en; e_addr = addr; e_wdata = wdata;
      tick();
      bubble();
    end
    if (tout) begin
      m_rdata_q = '0;
      e_err     = 1'b1;
    end else if (is_rd) begin
      m_rdata_q = rdata;
    end
    mem_rdy = 1; mem_rdata = 16'($urandom);
    e_stall = 0; e_re = 0; e_we = 0;
    tick();
    e_wb_regwrite = rw; e_wb_rd = rd; e_wb_data = m2r ? m_rdata_q : addr;
    {e_wb_call, e_wb_ret, e_wb_halt} = flags;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; chk_en = 0;
    zero_counts();
    model_reset();
    rst = 1;
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; mem_to_reg_in = 0;
    call_in = 0; ret_future_in = 0; HALT_in = 0; reg_rd_in = '0;
    alu_result_in = '0; save_word_data_in = '0; mem_rdy = 0; mem_rdata = '0;
    tick(); tick();
    chk("reset_outputs", 32'({mem_re, mem_we, stall, wb_regwrite, wb_call, wb_ret, wb_halt, mem_err}), 32'(0));
    chk("reset_wb_data", 32'(wb_data), 32'(0));
    chk("reset_mem_addr", 32'(mem_addr), 32'(0));
    rst = 0;
    chk_en = 1;

    // ALU op: one-cycle writeback, no stall.
    zero_counts();
    alu_op(1, 4'h3, 16'h1234, 3'b000);
    chk("alu_wb_data", 32'(wb_data), 32'h1234);
    chk("alu_wb_rd", 32'(wb_rd), 32'h3);
    chk("alu_wb_regwrite", 32'(wb_regwrite), 32'h1);
    chk("alu_stall_cycles", 32'(n_stall), 32'd0);
    alu_op(0, 4'h9, 16'h8001, 3'b101);

    // Zero-wait load.
    zero_counts();
    mem_op(1, 0, 1, 1, 4'h5, 16'h0040, 16'h0000, 16'hBEEF, 0, 3'b000);
    chk("load_re_cycles", 32'(n_re), 32'd1);
    chk("load_stall_cycles", 32'(n_stall), 32'd2);
    chk("load_wb_data", 32'(wb_data), 32'hBEEF);
    chk("load_wb_rd", 32'(wb_rd), 32'h5);
    chk("load_wb_regwrite", 32'(wb_regwrite), 32'h1);

    // Store with 4 wait cycles; pass-through flags bubble while stalled.
    zero_counts();
    mem_op(0, 1, 0, 0, 4'h2, 16'h0100, 16'h00AA, 16'h7777, 4, 3'b010);
    chk("store_we_cycles", 32'(n_we), 32'd5);
    chk("store_stall_cycles", 32'(n_stall), 32'd6);
    chk("store_wb_regwrite", 32'(wb_regwrite), 32'h0);

    // Read and write together: write wins, no read capture.
    zero_counts();
    mem_op(1, 1, 1, 1, 4'h7, 16'h0200, 16'h5555, 16'h1111, 2, 3'b111);
    chk("both_re_cycles", 32'(n_re), 32'd0);
    chk("both_we_cycles", 32'(n_we), 32'd3);
    chk("both_wb_data", 32'(wb_data), 32'hBEEF);

    // Back-to-back loads, then an ALU op.
    mem_op(1, 0, 1, 1, 4'h8, 16'h0080, 16'h0000, 16'hCAFE, 1, 3'b000);
    mem_op(1, 0, 1, 1, 4'hC, 16'h0082, 16'h0000, 16'h1357, 0, 3'b100);
    chk("b2b_wb_data", 32'(wb_data), 32'h1357);
    alu_op(1, 4'hA, 16'h0F0F, 3'b101);

`ifdef MEM_TIMEOUT_EN
    // mem_rdy in the expiry cycle wins; a longer wait times out.
    mem_op(1, 0, 1, 1, 4'h4, 16'h0300, 16'h0000, 16'hABCD, int'(TO) - 1, 3'b000);
    chk("late_rdy_err", 32'(mem_err), 32'h0);
    chk("late_rdy_data", 32'(wb_data), 32'hABCD);
    mem_op(1, 0, 1, 1, 4'h6, 16'h0400, 16'h0000, 16'h9999, 20, 3'b000);
    chk("timeout_err", 32'(mem_err), 32'h1);
    chk("timeout_data", 32'(wb_data), 32'h0000);
    alu_op(1, 4'hB, 16'h2222, 3'b001);
    chk("timeout_sticky", 32'(mem_err), 32'h1);
`else
    // Without the timeout, a long wait still completes normally.
    mem_op(1, 0, 1, 1, 4'h6, 16'h0400, 16'h0000, 16'h9999, 20, 3'b000);
    chk("long_wait_err", 32'(mem_err), 32'h0);
    chk("long_wait_data", 32'(wb_data), 32'h9999);
    alu_op(1, 4'hB, 16'h2222, 3'b001);
`endif

    // Reset in the middle of an access.
    chk_en = 0;
    RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 0; mem_to_reg_in = 1;
    reg_rd_in = 4'hD; alu_result_in = 16'h0500; mem_rdy = 0;
    tick();
    #2;
    chk("pre_reset_re", 32'(mem_re), 32'h1);
    rst = 1;
    #1;
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_wb_flags", 32'({wb_regwrite, wb_call, wb_ret, wb_halt, mem_err}), 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    tick();
    MemRead_in = 0; RegWrite_in = 0; mem_to_reg_in = 0;
    rst = 0;
    model_reset();
    chk_en = 1;
    alu_op(1, 4'h1, 16'h4321, 3'b000);
    mem_op(1, 0, 1, 1, 4'hE, 16'h0600, 16'h0000, 16'h6006, 2, 3'b000);
    chk("post_reset_load", 32'(wb_data), 32'h6006);
    alu_op(0, 4'h0, 16'h0000, 3'b000);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumes the EX/MEM pipeline register outputs and drives the data-memory request interface.
- Holds the request stable until the memory responds, stalling the upstream pipeline meanwhile.
- Registers results toward MEM/WB: load data or ALU result, plus destination and control.
- 16-bit datapath, 4-bit register specifiers, variable-latency data memory with a ready handshake.

Parameters:
- DW, 16, data/address width.
- RW, 4, register-specifier width.
- TIMEOUT_CYCLES, 255, ACCESS-state cycle limit, used only with MEM_TIMEOUT_EN. Counter width 8 bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
RegWrite_in  in  1  regfile write for this instruction
MemWrite_in  in  1  store request
MemRead_in  in  1  load request
mem_to_reg_in  in  1  select load data, not ALU result, for writeback
call_in  in  1  call marker, passed through
ret_future_in  in  1  future ret_wb, passed through
HALT_in  in  1  halt marker, passed through
reg_rd_in  in  RW  destination register
alu_result_in  in  DW  ALU result; memory address for load/store
save_word_data_in  in  DW  store data
mem_rdy  in  1  memory completes the current request
mem_rdata  in  DW  load data, valid when mem_rdy=1
mem_addr  out  DW  request address
mem_wdata  out  DW  store data
mem_re  out  1  read request
mem_we  out  1  write request
stall  out  1  freeze EX/MEM and earlier stages
wb_regwrite  out  1  to MEM/WB
wb_rd  out  RW  to MEM/WB
wb_data  out  DW  to MEM/WB
wb_call  out  1  to MEM/WB
wb_ret  out  1  to MEM/WB
wb_halt  out  1  to MEM/WB
mem_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state=IDLE; every output is 0; rdata_q=0; timeout counter=0.
- Reset mid-access aborts immediately: mem_re and mem_we drop asynchronously. There is no replay; upstream is also reset.
- memop = MemRead_in | MemWrite_in.
  - If both are high (illegal), the write wins and the read is ignored (no rdata capture).
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, memop=0: stay in IDLE.
  - IDLE, memop=1: go to ACCESS; latch mem_addr=alu_result_in and mem_wdata=save_word_data_in; register mem_we=MemWrite_in and mem_re=MemRead_in&~MemWrite_in.
  - ACCESS: mem_re/mem_we/mem_addr/mem_wdata are held constant.
  - ACCESS, mem_rdy=1: capture rdata_q=mem_rdata if reading; clear mem_re/mem_we; go to DONE.
  - DONE: go to IDLE unconditionally. No new request is launched in DONE, because the inputs still present the completed instruction.
- stall is combinational: (IDLE & memop) | ACCESS. It is 0 in DONE, so upstream advances at the end of DONE.
- mem_rdy is ignored outside ACCESS.
- WB outputs are registered and update every cycle.
  - stall=1: insert a bubble. wb_regwrite, wb_call, wb_ret and wb_halt load 0; wb_rd and wb_data hold.
  - stall=0: wb_regwrite/rd/call/ret/halt load the corresponding inputs. wb_data loads rdata_q if (mem_to_reg_in & state==DONE), otherwise alu_result_in.
- Latency:
  - Non-memory instruction: 1 cycle, input to wb_*.
  - Memory op detected in cycle T with mem_rdy first high in cycle T+1+N (N≥0 wait cycles): DONE in T+2+N; wb_* valid after that edge.
  - Minimum load latency: 3 cycles.
- Stores: same sequencing. wb_regwrite follows RegWrite_in (normally 0).
- Back-to-back memory ops: the second is detected in the IDLE cycle following DONE. There is no overlap.
- No ordering hazards: one outstanding request at most.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with mem_rdy=0.
  - When it reaches TIMEOUT_CYCLES without mem_rdy: set mem_err=1 (sticky until rst), clear mem_re/mem_we, set rdata_q=16'h0000, go to DONE.
  - A mem_rdy arriving in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely; mem_err is tied 0.

Test Plan:
- Reset mid-ACCESS: assert rst while mem_re=1 → mem_re=0 and stall=0 in the same cycle; state IDLE; all wb_* 0.
- ALU op: RegWrite_in=1, reg_rd_in=4'h3, alu_result_in=16'h1234, no memop → next edge wb_regwrite=1, wb_rd=3, wb_data=16'h1234; stall never high.
- Load, zero-wait memory (mem_rdy tied 1): MemRead_in=1, mem_to_reg_in=1, alu_result_in=16'h0040, mem_rdata=16'hBEEF, reg_rd_in=5 → mem_re high exactly 1 cycle with mem_addr=16'h0040; stall high 2 cycles; then wb_data=16'hBEEF, wb_rd=5, wb_regwrite=1.
- Store with 4 wait cycles: MemWrite_in=1, addr 16'h0100, data 16'h00AA → mem_we/addr/data stable 5 cycles until mem_rdy; wb_regwrite=0 throughout.
- Both MemRead_in=1 and MemWrite_in=1 → only mem_we asserted; mem_re stays 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_rdy held 0 → after 8 ACCESS cycles mem_err=1, mem_re=0, wb_data=16'h0000; mem_err stays 1 until rst.
